// File: rtl/kinrow_game_engine_if.sv
// kinrow_game_engine_if: move handshake and game status between controller and engine
interface kinrow_game_engine_if #(parameter int BOARD_N = 3, parameter int COORD_W = 4);
  logic new_game, move_valid, move_ready;
  logic [1:0] move_player;
  logic [COORD_W-1:0] move_row, move_col;
  logic illegal_move, move_done, over;
  logic [1:0] turn, winner;
  logic [7:0] move_count;
  logic [2*BOARD_N*BOARD_N-1:0] board;
  modport master(output new_game, move_valid, move_player, move_row, move_col,
                 input move_ready, illegal_move, move_done, turn, over, winner, move_count, board);
  modport slave(input new_game, move_valid, move_player, move_row, move_col,
                output move_ready, illegal_move, move_done, turn, over, winner, move_count, board);
endinterface

// File: rtl/kinrow_game_engine.sv
// kinrow_game_engine: NxN K-in-a-row engine with move validation and a cell-per-cycle win scan
module kinrow_game_engine #(
  parameter int BOARD_N = 3,
  parameter int WIN_K = 3,
  parameter int COORD_W = 4,
  parameter int FIRST_PLAYER = 1
) (
  input logic clk,
  input logic reset,
  kinrow_game_engine_if.slave bus
);
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, SCAN = 3'd2, RESULT = 3'd3, OVER = 3'd4;
  localparam logic [COORD_W-1:0] LAST = COORD_W'(BOARD_N - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [5:0] KW = 6'(WIN_K);
  localparam logic [4:0] KM1 = 5'(WIN_K - 1);
  localparam logic [7:0] CELLS8 = 8'(CELLS);
  localparam logic [1:0] FIRST = 2'(FIRST_PLAYER);

  logic [2:0] state;
  logic [2*CELLS-1:0] cells;
  logic [1:0] turn, winner, player, dir;
  logic over, illegal, done, won, side;
  logic [7:0] count;
  logic [COORD_W-1:0] row, col, pr, pc, nr, nc;
  logic [4:0] step;
  logic [5:0] run, run_n;
  logic r_up, r_dn, c_up, c_dn, at_edge, owned, hit, side_end, last, bad;

  // constant-index lookup: out-of-range coordinates read as empty and never alias a cell
  function automatic logic [1:0] cell_at(logic [2*CELLS-1:0] b, logic [COORD_W-1:0] r, logic [COORD_W-1:0] c);
    cell_at = 2'b00;
    for (int i = 0; i < BOARD_N; i++)
      for (int j = 0; j < BOARD_N; j++)
        if (COORD_W'(i) == r && COORD_W'(j) == c) cell_at = b[2*(i*BOARD_N+j)+:2];
  endfunction

  function automatic logic [2*CELLS-1:0] mark(logic [2*CELLS-1:0] b, logic [COORD_W-1:0] r,
                                               logic [COORD_W-1:0] c, logic [1:0] p);
    mark = b;
    for (int i = 0; i < BOARD_N; i++)
      for (int j = 0; j < BOARD_N; j++)
        if (COORD_W'(i) == r && COORD_W'(j) == c) mark[2*(i*BOARD_N+j)+:2] = p;
  endfunction

  // direction 0..3 = horizontal, vertical, diagonal, anti-diagonal; side 1 walks the negative way
  assign r_up = dir != 2'd0 && !side;
  assign r_dn = dir != 2'd0 && side;
  assign c_up = dir == 2'd1 ? 1'b0 : dir == 2'd3 ? side : !side;
  assign c_dn = dir == 2'd1 ? 1'b0 : dir == 2'd3 ? !side : side;
  assign at_edge = (r_up && pr == LAST) || (r_dn && pr == '0) || (c_up && pc == LAST) || (c_dn && pc == '0);
  assign nr = r_up ? pr + ONE : r_dn ? pr - ONE : pr;
  assign nc = c_up ? pc + ONE : c_dn ? pc - ONE : pc;
  assign owned = !at_edge && cell_at(cells, nr, nc) == player;
  assign run_n = run + {5'd0, owned};
  assign hit = run_n >= KW;
  assign side_end = !owned || step == KM1;
  assign last = side_end && side && dir == 2'd3;
  assign bad = row > LAST || col > LAST || cell_at(cells, row, col) != 2'b00 || player != turn ||
               (player != 2'b01 && player != 2'b10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cells <= '0;
      turn <= FIRST;
      over <= 1'b0;
      winner <= 2'b00;
      count <= 8'd0;
      illegal <= 1'b0;
      done <= 1'b0;
      won <= 1'b0;
    end else if (bus.new_game) begin
      state <= IDLE;
      cells <= '0;
      turn <= FIRST;
      over <= 1'b0;
      winner <= 2'b00;
      count <= 8'd0;
      illegal <= 1'b0;
      done <= 1'b0;
      won <= 1'b0;
    end else begin
      illegal <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (bus.move_valid && !over) state <= CHECK;
        CHECK: begin
          illegal <= bad;
          state <= bad ? IDLE : SCAN;
          if (!bad) begin
            cells <= mark(cells, row, col, player);
            count <= count + 8'd1;
          end
        end
        SCAN: if (hit || last) begin
          won <= hit;
          state <= RESULT;
        end
        RESULT: begin
          done <= 1'b1;
          over <= won || count == CELLS8;
          winner <= won ? player : count == CELLS8 ? 2'b11 : 2'b00;
          state <= won || count == CELLS8 ? OVER : IDLE;
          if (!won && count != CELLS8) turn <= {turn[0], turn[1]};
        end
        default: state <= OVER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      player <= bus.move_player;
      row <= bus.move_row;
      col <= bus.move_col;
    end
    if (state == CHECK) begin
      dir <= 2'd0;
      side <= 1'b0;
      pr <= row;
      pc <= col;
      step <= 5'd1;
      run <= 6'd1;
    end else if (state == SCAN && side_end) begin
      dir <= dir + {1'b0, side};
      side <= !side;
      pr <= row;
      pc <= col;
      step <= 5'd1;
      run <= side ? 6'd1 : run_n;
    end else if (state == SCAN) begin
      pr <= nr;
      pc <= nc;
      step <= step + 5'd1;
      run <= run_n;
    end
  end

  assign bus.move_ready = state == IDLE && !over;
  assign bus.illegal_move = illegal;
  assign bus.move_done = done;
  assign bus.turn = turn;
  assign bus.over = over;
  assign bus.winner = winner;
  assign bus.move_count = count;
  assign bus.board = cells;
endmodule

// File: tb/tb_kinrow_game_engine.sv
// tb_kinrow_game_engine: directed vector table plus random games against a rule-level model, N=3/K=3 and N=5/K=4
module tb_kinrow_game_engine;
  logic clk = 0, reset = 1, ng = 0, mv = 0;
  logic [1:0] mp = 0;
  logic [3:0] mr = 0, mc = 0;
  int sel = 0, n_cur = 3, k_cur = 3, n_cmp = 0, n_bad = 0;
  int mb[15][15];
  int m_turn, m_cnt, m_over, m_win;

  kinrow_game_engine_if #(.BOARD_N(3), .COORD_W(4)) i3();
  kinrow_game_engine_if #(.BOARD_N(5), .COORD_W(4)) i5();
  kinrow_game_engine #(.BOARD_N(3), .WIN_K(3), .COORD_W(4), .FIRST_PLAYER(1)) d3(.clk(clk), .reset(reset), .bus(i3.slave));
  kinrow_game_engine #(.BOARD_N(5), .WIN_K(4), .COORD_W(4), .FIRST_PLAYER(1)) d5(.clk(clk), .reset(reset), .bus(i5.slave));

  assign i3.new_game = ng;
  assign i3.move_valid = mv;
  assign i3.move_player = mp;
  assign i3.move_row = mr;
  assign i3.move_col = mc;
  assign i5.new_game = ng;
  assign i5.move_valid = mv;
  assign i5.move_player = mp;
  assign i5.move_row = mr;
  assign i5.move_col = mc;

  logic o_ready, o_ill, o_done, o_over;
  logic [1:0] o_turn, o_win;
  logic [7:0] o_cnt;
  logic [63:0] o_board;
  assign o_ready = sel != 0 ? i5.move_ready : i3.move_ready;
  assign o_ill = sel != 0 ? i5.illegal_move : i3.illegal_move;
  assign o_done = sel != 0 ? i5.move_done : i3.move_done;
  assign o_over = sel != 0 ? i5.over : i3.over;
  assign o_turn = sel != 0 ? i5.turn : i3.turn;
  assign o_win = sel != 0 ? i5.winner : i3.winner;
  assign o_cnt = sel != 0 ? i5.move_count : i3.move_count;
  assign o_board = sel != 0 ? 64'(i5.board) : 64'(i3.board);

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {int sel; int ng; int p; int r; int c; int ill; int turn; int over; int win; int cnt;} vec_t;
  vec_t tv[$];

  function automatic void add(int s, int n, int p, int r, int c, int ill, int t, int o, int w, int cn);
    vec_t v;
    v.sel = s; v.ng = n; v.p = p; v.r = r; v.c = c; v.ill = ill; v.turn = t; v.over = o; v.win = w; v.cnt = cn;
    tv.push_back(v);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] st(int t, int o, int w, int c);
    return 64'((t << 16) | (o << 12) | (w << 8) | c);
  endfunction

  function automatic void m_clear();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) mb[r][c] = 0;
    m_turn = 1; m_cnt = 0; m_over = 0; m_win = 0;
  endfunction

  // longest contiguous line through (r,c) in any of the four directions reaching K wins
  function automatic int m_wins(int r, int c, int p);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        int rr = r + s * dr[d];
        int cc = c + s * dc[d];
        while (rr >= 0 && rr < n_cur && cc >= 0 && cc < n_cur && mb[rr][cc] == p) begin
          n++; rr += s * dr[d]; cc += s * dc[d];
        end
      end
      if (n >= k_cur) return 1;
    end
    return 0;
  endfunction

  function automatic int m_move(int p, int r, int c);
    if (r >= n_cur || c >= n_cur || p != m_turn || (p != 1 && p != 2) || mb[r][c] != 0) return 1;
    mb[r][c] = p;
    m_cnt++;
    if (m_wins(r, c, p) != 0) begin m_over = 1; m_win = p; end
    else if (m_cnt == n_cur * n_cur) begin m_over = 1; m_win = 3; end
    else m_turn = 3 - m_turn;
    return 0;
  endfunction

  function automatic logic [63:0] exp_board();
    logic [63:0] e = '0;
    for (int r = 0; r < n_cur; r++)
      for (int c = 0; c < n_cur; c++) e[2*(r*n_cur+c)+:2] = 2'(mb[r][c]);
    return e;
  endfunction

  task automatic set_sel(int s);
    sel = s; n_cur = s != 0 ? 5 : 3; k_cur = s != 0 ? 4 : 3;
  endtask

  task automatic new_game();
    @(negedge clk); ng = 1;
    @(negedge clk); ng = 0;
    m_clear();
  endtask

  task automatic do_move(input int p, input int r, input int c, output int gi, output int gd, output int lat);
    int w = 0;
    gi = 0; gd = 0; lat = 0;
    @(negedge clk); mp = 2'(p); mr = 4'(r); mc = 4'(c); mv = 1;
    while (!o_ready && w < 40) begin @(negedge clk); w++; end
    if (!o_ready) begin mv = 0; chk("accept_ready", o_ready, 1); return; end
    @(posedge clk);
    @(negedge clk); mv = 0; lat = 1;
    while (!o_ill && !o_done && lat < 8 * k_cur + 10) begin @(negedge clk); lat++; end
    gi = int'(o_ill); gd = int'(o_done);
    if (gi == 0 && gd == 0) chk("pulse_seen", o_ill | o_done, 1);
    else begin @(negedge clk); chk("pulse_width", {o_ill, o_done}, 0); end
  endtask

  task automatic chk_model(string nm);
    chk({nm, "_board"}, o_board, exp_board());
    chk({nm, "_status"}, st(o_turn, o_over, o_win, o_cnt), st(m_turn, m_over, m_win, m_cnt));
  endtask

  initial begin
    int gi, gd, lat, ei, p, r, c;
    m_clear();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      chk("reset_ready", o_ready, 1);
      chk("reset_pulses", {o_ill, o_done}, 0);
      chk_model("reset");
    end

    // N=3 row win
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 1); add(0, 0, 2, 1, 1, 0, 1, 0, 0, 2); add(0, 0, 1, 0, 1, 0, 2, 0, 0, 3);
    add(0, 0, 2, 2, 2, 0, 1, 0, 0, 4); add(0, 0, 1, 0, 2, 0, 1, 1, 1, 5);
    // illegal moves
    add(0, 1, 1, 1, 1, 0, 2, 0, 0, 1); add(0, 0, 1, 0, 0, 1, 2, 0, 0, 1); add(0, 0, 2, 1, 1, 1, 2, 0, 0, 1);
    add(0, 0, 2, 3, 0, 1, 2, 0, 0, 1); add(0, 0, 3, 0, 0, 1, 2, 0, 0, 1); add(0, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    add(0, 0, 2, 0, 3, 1, 2, 0, 0, 1);
    // draw
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 1); add(0, 0, 2, 0, 1, 0, 1, 0, 0, 2); add(0, 0, 1, 0, 2, 0, 2, 0, 0, 3);
    add(0, 0, 2, 1, 1, 0, 1, 0, 0, 4); add(0, 0, 1, 1, 0, 0, 2, 0, 0, 5); add(0, 0, 2, 1, 2, 0, 1, 0, 0, 6);
    add(0, 0, 1, 2, 1, 0, 2, 0, 0, 7); add(0, 0, 2, 2, 0, 0, 1, 0, 0, 8); add(0, 0, 1, 2, 2, 0, 1, 1, 3, 9);
    // corner wins (0,0) and (2,2)
    add(0, 1, 1, 0, 1, 0, 2, 0, 0, 1); add(0, 0, 2, 2, 0, 0, 1, 0, 0, 2); add(0, 0, 1, 0, 2, 0, 2, 0, 0, 3);
    add(0, 0, 2, 2, 1, 0, 1, 0, 0, 4); add(0, 0, 1, 0, 0, 0, 1, 1, 1, 5);
    add(0, 1, 1, 2, 0, 0, 2, 0, 0, 1); add(0, 0, 2, 0, 0, 0, 1, 0, 0, 2); add(0, 0, 1, 2, 1, 0, 2, 0, 0, 3);
    add(0, 0, 2, 0, 1, 0, 1, 0, 0, 4); add(0, 0, 1, 2, 2, 0, 1, 1, 1, 5);
    // N=5/K=4 anti-diagonal win by P2
    add(1, 1, 1, 0, 0, 0, 2, 0, 0, 1); add(1, 0, 2, 0, 4, 0, 1, 0, 0, 2); add(1, 0, 1, 1, 0, 0, 2, 0, 0, 3);
    add(1, 0, 2, 1, 3, 0, 1, 0, 0, 4); add(1, 0, 1, 3, 3, 0, 2, 0, 0, 5); add(1, 0, 2, 2, 2, 0, 1, 0, 0, 6);
    add(1, 0, 1, 4, 4, 0, 2, 0, 0, 7); add(1, 0, 2, 3, 1, 0, 2, 1, 2, 8);
    // N=5/K=4 corner (4,4) diagonal win, far out-of-range coordinates
    add(1, 1, 1, 1, 1, 0, 2, 0, 0, 1); add(1, 0, 2, 0, 5, 1, 2, 0, 0, 1); add(1, 0, 2, 15, 0, 1, 2, 0, 0, 1);
    add(1, 0, 2, 0, 1, 0, 1, 0, 0, 2); add(1, 0, 1, 2, 2, 0, 2, 0, 0, 3); add(1, 0, 2, 0, 2, 0, 1, 0, 0, 4);
    add(1, 0, 1, 3, 3, 0, 2, 0, 0, 5); add(1, 0, 2, 0, 3, 0, 1, 0, 0, 6); add(1, 0, 1, 4, 4, 0, 1, 1, 1, 7);

    foreach (tv[i]) begin
      set_sel(tv[i].sel);
      if (tv[i].ng != 0) new_game();
      ei = m_move(tv[i].p, tv[i].r, tv[i].c);
      do_move(tv[i].p, tv[i].r, tv[i].c, gi, gd, lat);
      chk($sformatf("v%0d_illegal", i), gi, tv[i].ill);
      chk($sformatf("v%0d_done", i), gd, tv[i].ill == 0 ? 1 : 0);
      chk($sformatf("v%0d_status", i), st(o_turn, o_over, o_win, o_cnt), st(tv[i].turn, tv[i].over, tv[i].win, tv[i].cnt));
      chk($sformatf("v%0d_board", i), o_board, exp_board());
      if (gd != 0) chk($sformatf("v%0d_latency_ok", i), lat <= 8 * (k_cur - 1) + 3, 1);
    end

    // game over: moves are ignored
    @(negedge clk); mp = 2; mr = 0; mc = 0; mv = 1;
    repeat (6) begin
      @(negedge clk);
      chk("over_ready", o_ready, 0);
      chk("over_pulses", {o_ill, o_done}, 0);
    end
    mv = 0;
    chk_model("over_hold");

    // new_game during SCAN on N=5
    set_sel(1);
    new_game();
    ei = m_move(1, 2, 2);
    @(negedge clk); mp = 1; mr = 2; mc = 2; mv = 1;
    @(posedge clk);
    @(negedge clk); mv = 0;
    @(negedge clk);
    chk("scan_board_marked", o_board, exp_board());
    ng = 1;
    @(negedge clk); ng = 0;
    m_clear();
    chk("abort_ready", o_ready, 1);
    chk_model("abort");
    repeat (4) begin @(negedge clk); chk("abort_pulses", {o_ill, o_done}, 0); end

    // new_game together with move_valid drops the move
    set_sel(0);
    @(negedge clk); ng = 1; mv = 1; mp = 1; mr = 0; mc = 0;
    @(negedge clk); ng = 0; mv = 0;
    m_clear();
    chk("ngmv_ready", o_ready, 1);
    chk_model("ngmv");
    repeat (3) begin @(negedge clk); chk("ngmv_pulses", {o_ill, o_done}, 0); end

    // asynchronous reset in the middle of a scan
    ei = m_move(1, 1, 1);
    @(negedge clk); mp = 1; mr = 1; mc = 1; mv = 1;
    @(posedge clk);
    @(negedge clk); mv = 0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    m_clear();
    chk_model("areset");
    @(negedge clk); reset = 0;
    repeat (12) begin @(negedge clk); chk("areset_pulses", {o_ill, o_done}, 0); end
    chk("areset_ready", o_ready, 1);

    // random games against the model
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      new_game();
      for (int i = 0; i < 120; i++) begin
        if (m_over != 0) new_game();
        p = $urandom_range(0, 9) < 9 ? m_turn : int'($urandom_range(0, 3));
        r = $urandom_range(0, 9) < 9 ? int'($urandom_range(0, n_cur - 1)) : int'($urandom_range(0, 15));
        c = $urandom_range(0, 9) < 9 ? int'($urandom_range(0, n_cur - 1)) : int'($urandom_range(0, 15));
        ei = m_move(p, r, c);
        do_move(p, r, c, gi, gd, lat);
        chk($sformatf("rnd%0d_%0d_pulses", s, i), {gi[0], gd[0]}, {ei[0], ~ei[0]});
        chk_model($sformatf("rnd%0d_%0d", s, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kinrow_game_engine.md
Name: kinrow_game_engine

Overview:
- Parametrised successor to the fixed 3x3 tic-tac-toe engine: an NxN board with a K-in-a-row win rule.
- Accepts moves through a valid/ready handshake from the game controller and rejects illegal moves with a one-cycle pulse.
- Runs a sequential, cell-per-cycle win scan through the last placed cell.
- Exports a flat board vector to the TFT renderer.

Parameters:
BOARD_N, 3, board side length; legal range 3..15
WIN_K, 3, contiguous marks needed to win; legal range 2..BOARD_N
COORD_W, 4, row/col coordinate width; 2^COORD_W >= BOARD_N
FIRST_PLAYER, 1, player who moves first after reset or new_game (1 or 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
new_game  in  1  synchronous clear of board, turn and result; has priority over everything else
move_valid  in  1  move request
move_ready  out  1  engine can accept a move
move_player  in  2  requesting player: 01=P1, 10=P2
move_row  in  COORD_W  target row, 0-based
move_col  in  COORD_W  target column, 0-based
illegal_move  out  1  one-cycle pulse: last accepted move rejected
move_done  out  1  one-cycle pulse: legal move placed and scan finished
turn  out  2  player expected to move next (01/10)
over  out  1  game finished
winner  out  2  00 none, 01 P1, 10 P2, 11 draw
move_count  out  8  legal moves placed this game
board  out  2*BOARD_N*BOARD_N  cell (r,c) at bits [2*(r*BOARD_N+c)+:2]; 00 empty, 01 P1, 10 P2

Behaviour:
- Reset values (also applied by new_game on the next edge):
  - board all 0, turn=FIRST_PLAYER, over=0, winner=00, move_count=0.
  - illegal_move=0, move_done=0, state IDLE, move_ready=1.
- States: IDLE, CHECK, SCAN, RESULT, OVER.
- IDLE:
  - move_ready=1 only in IDLE with over=0.
  - A move is accepted on an edge where move_valid & move_ready; the engine latches player/row/col and goes to CHECK.
- CHECK (1 cycle). The move is illegal if any of:
  - row >= BOARD_N or col >= BOARD_N;
  - the target cell is non-empty;
  - move_player != turn;
  - move_player is not 01 or 10.
- Illegal move: illegal_move pulses high for exactly the cycle after CHECK. Board, turn and move_count are unchanged. Return to IDLE.
- Legal move: cell written, move_count+1, enter SCAN. The board output reflects the new mark from the first SCAN cycle.
- SCAN:
  - Directions are examined in order: horizontal (0,+1), vertical (+1,0), diagonal (+1,+1), anti-diagonal (+1,-1).
  - Per direction: run=1; step the positive side, then the negative side, one cell per cycle.
  - A side stops at the board edge, at a cell not owned by the mover, or after K-1 steps.
  - If run >= WIN_K, the win is found and the scan exits immediately to RESULT.
  - Worst-case scan length is 8*(WIN_K-1) cycles.
  - Edge-bound tests use unsigned-safe compares; wrap-around never aliases a cell.
- RESULT (1 cycle):
  - move_done pulses.
  - Win: over=1, winner=mover, go to OVER.
  - No win and move_count==BOARD_N*BOARD_N: over=1, winner=11, go to OVER.
  - Otherwise: turn toggles, go to IDLE.
- OVER: move_ready=0; all moves are ignored. The engine stays in OVER until new_game or reset.
- Throughput: a legal move occupies the engine from acceptance to return to IDLE; move_ready is low throughout.
- new_game:
  - Aborts CHECK/SCAN/RESULT mid-operation; no move_done or illegal_move pulse is emitted for the aborted move.
  - If new_game and move_valid are high together, new_game wins and the move is dropped.
- Asynchronous reset mid-scan leaves the board empty and suppresses all pulses.
- winner and over change only in RESULT or on clear.

Test Plan:
- Reset, N=3/K=3: P1 (0,0), P2 (1,1), P1 (0,1), P2 (2,2), P1 (0,2) -> move_done after each move; after the last, over=1, winner=01, move_ready=0.
- P1 plays (1,1); P1 plays again -> illegal_move pulse; P2 plays (1,1) -> illegal_move pulse; P2 plays (3,0) -> illegal_move pulse; throughout, board bits for (1,1)=01, move_count=1, turn=10.
- Full 9-move sequence with no line -> winner=11, over=1, move_count=9.
- N=5/K=4, anti-diagonal (0,4),(1,3),(2,2) then (3,1) by P2, with P1 fillers -> win detected on the 4th P2 mark; winner=10. Also, 3-in-a-row on N=5/K=4 -> no win, turn toggles.
- Assert new_game during SCAN, and new_game with move_valid together -> board=0, move_count=0, turn=FIRST_PLAYER, no pulses, move_ready=1 on the following cycle.
- Winning move placed at a corner, (0,0) and (N-1,N-1) -> scan stops at the edges, no spurious wrap hits; latency from acceptance to move_done is <= 8*(K-1)+3 cycles.
